pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives PC write-enable, IF/ID write/flush, ID/EX hold (stall) and bubble-insert (control-field zeroing mux), EX/MEM hold and MEM/WB bubble.
- Resolves load-use hazards, control-transfer redirects, multi-cycle data-memory accesses and HALT/resume.
- Keeps saturating stall/flush performance counters.

Parameters:
- MEM_LAT, 2, data-memory access latency in cycles (>=1; 1 = single-cycle, never freezes).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- id_rs  in  3  rs field of instruction in ID.
- id_rt  in  3  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_jump  in  1  unconditional jump/call resolved in ID.
- id_halt  in  1  HALT decoded in ID.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  3  destination register of EX instruction.
- ex_redirect  in  1  taken branch/ret/for_loop resolved in EX.
- mem_access  in  1  MEM-stage instruction reads or writes data memory.
- resume  in  1  single-cycle pulse; leaves HALT.
- pc_we  out  1  PC register write enable.
- if_id_we  out  1  IF/ID write enable (0 = hold).
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_stall  out  1  ID/EX hold.
- id_ex_bubble  out  1  zero ID/EX control inputs (reg_write, mem_*, branch, jump, call, ret, for_loop).
- ex_mem_stall  out  1  EX/MEM hold.
- mem_wb_bubble  out  1  MEM/WB loads reg_write=0.
- state  out  2  FSM state (RUN=0, MEM_WAIT=1, HALT=2).
- stall_cnt  out  CNT_W  cycles with pc_we=0.
- flush_cnt  out  CNT_W  cycles with if_id_flush=1.

Behaviour:
- Outputs are combinational from state, counter and inputs. State, wait counter and perf counters are registered.
- While rst=1:
  - All control outputs are 0.
  - state=RUN; wait counter and perf counters are 0.
- Default, RUN with no event: pc_we=1, if_id_we=1, all stall/flush/bubble outputs 0.
- freeze condition: (RUN && mem_access && MEM_LAT>1) || (MEM_WAIT && wcnt!=0).
- Freeze has top priority. Under freeze:
  - pc_we=0, if_id_we=0, id_ex_stall=1, ex_mem_stall=1, mem_wb_bubble=1.
  - if_id_flush=0, id_ex_bubble=0.
  - All other events are ignored; they persist because stages are held.
- RUN entering freeze: load wcnt=MEM_LAT-2, next=MEM_WAIT.
- MEM_WAIT:
  - wcnt!=0: freeze, decrement.
  - wcnt==0: release cycle with default outputs; events are not evaluated; next=RUN.
  - Net effect: the access occupies MEM for exactly MEM_LAT cycles.
- RUN without freeze, priority ex_redirect > load-use > id_halt > id_jump:
  - ex_redirect: pc_we=1, if_id_flush=1, id_ex_bubble=1.
  - load-use, i.e. ex_mem_read && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)): pc_we=0, if_id_we=0, id_ex_bubble=1. Exactly one bubble per load.
  - id_halt: pc_we=0, if_id_we=0, id_ex_bubble=1; next=HALT.
  - id_jump: pc_we=1, if_id_flush=1.
- HALT:
  - pc_we=0, if_id_we=0, id_ex_bubble=1; downstream stages drain.
  - mem_access in HALT still freezes per MEM_LAT rules; state stays HALT.
  - resume (not frozen): next=RUN with default outputs that cycle.
  - HALT under ex_redirect cannot occur: redirect squashes the halt in ID.
- stall_cnt increments on every non-reset cycle with pc_we=0. flush_cnt increments when if_id_flush=1. Both saturate at all-ones, no wrap.
- rst mid-MEM_WAIT or mid-HALT returns immediately to RUN and clears wcnt.
- Unused state 3: next=RUN, outputs as RUN default.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 for one cycle -> pc_we=0, if_id_we=0, id_ex_bubble=1 that cycle only; stall_cnt=1.
- Redirect beats load-use: ex_redirect=1 with the load-use match above -> pc_we=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1, stall_cnt unchanged.
- MEM_LAT=4, mem_access=1 held -> freeze outputs for 3 cycles (state 0,1,1), then release cycle with state=1, then state=0; stall_cnt=3.
- MEM_LAT=1, mem_access=1 -> no freeze, state stays 0.
- Halt: id_halt=1 -> next state=2, pc_we=0 held 5 cycles; resume pulse -> state=0, pc_we=1; stall_cnt=6.
- Saturation: CNT_W=4, hold load-use for 20 cycles -> stall_cnt=15. Assert rst mid-MEM_WAIT -> state=0 and counters 0 asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage 16-bit pipeline. It resolves
//   load-use hazards, control-transfer redirects, multi-cycle data-memory
//   accesses and HALT/resume, and keeps saturating stall/flush counters.
//
// Parameters
//   MEM_LAT  data-memory access latency in cycles (>=1; 1 never freezes)
//   CNT_W    width of the performance counters
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   id_rs, id_rt             source register fields of the ID instruction
//   id_uses_rs, id_uses_rt   ID instruction actually reads rs / rt
//   id_jump, id_halt         jump/call or HALT decoded in ID
//   ex_mem_read, ex_rd       EX instruction is a load, and its destination
//   ex_redirect              taken branch/ret/for_loop resolved in EX
//   mem_access               MEM-stage instruction touches data memory
//   resume                   one-cycle pulse that leaves HALT
//   pc_we .. mem_wb_bubble   pipeline register enables / flush / bubble
//   state                    RUN=0, MEM_WAIT=1, HALT=2
//   stall_cnt, flush_cnt     saturating counts of pc_we=0 / if_id_flush=1
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             resume,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Wait counter holds the number of extra frozen cycles after the first one.
  localparam int               WCNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam bit               MULTI     = (MEM_LAT > 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = MULTI ? WCNT_W'(MEM_LAT - 2) : '0;

  state_t            cur, nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  // Set while a memory access is being waited out without leaving HALT.
  logic              hwait, hwait_nxt;
  logic              load_use;
  logic              freeze;

  assign state = cur;

  assign load_use = ex_mem_read &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

  // A MEM_WAIT cycle with wcnt==0 is the release cycle and is not frozen.
  always_comb begin
    freeze = 1'b0;
    case (cur)
      RUN:      freeze = mem_access && MULTI;
      MEM_WAIT: freeze = (wcnt != '0);
      HALT:     freeze = hwait ? (wcnt != '0) : (mem_access && MULTI);
      default:  freeze = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= RUN;
      wcnt  <= '0;
      hwait <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      cur   <= nxt;
      wcnt  <= wcnt_nxt;
      hwait <= hwait_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    nxt       = cur;
    wcnt_nxt  = wcnt;
    hwait_nxt = hwait;
    case (cur)
      RUN: begin
        if (freeze) begin
          nxt      = MEM_WAIT;
          wcnt_nxt = WCNT_LOAD;
        end else if (!ex_redirect && !load_use && id_halt) begin
          nxt = HALT;
        end
      end
      MEM_WAIT: begin
        if (wcnt != '0) wcnt_nxt = wcnt - WCNT_W'(1);
        else            nxt      = RUN;
      end
      HALT: begin
        if (freeze) begin
          if (hwait) begin
            wcnt_nxt = wcnt - WCNT_W'(1);
          end else begin
            hwait_nxt = 1'b1;
            wcnt_nxt  = WCNT_LOAD;
          end
        end else begin
          hwait_nxt = 1'b0;
          if (resume) nxt = RUN;
        end
      end
      default: begin
        nxt       = RUN;
        wcnt_nxt  = '0;
        hwait_nxt = 1'b0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else if (freeze) begin
      // Every stage holds; pending events persist and are seen later.
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      case (cur)
        RUN: begin
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use || id_halt) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_jump) begin
            if_id_flush = 1'b1;
          end
        end
        HALT: begin
          if (!resume) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        default: ;  // MEM_WAIT release cycle and unused encoding
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only control/status registers are reset here; there is no memory.
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != '1))      stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
